// File: rtl/multichannel_decimator_pkg.sv
// Shared types and helpers for the multichannel decimator.
//   ratio_t      : ratio/counter word sized for the default RMAX
//   clamp_ratio  : maps a requested ratio into the legal range 1..rmax
//   out_width    : per-channel output width (input width + ratio width)
//   chan_lsb     : bit offset of channel c in a packed multi-channel bus
package multichannel_decimator_pkg;

  localparam int DEF_RMAX = 32;
  localparam int DEF_RW   = $clog2(DEF_RMAX + 1);

  typedef logic [DEF_RW-1:0] ratio_t;

  // A ratio of 0 is meaningless, so it is treated as pass-through.
  // Anything above rmax saturates.
  function automatic int clamp_ratio(input int r, input int rmax);
    if (r == 0)
      return 1;
    else if (r > rmax)
      return rmax;
    else
      return r;
  endfunction

  function automatic int out_width(input int w, input int rw);
    return w + rw;
  endfunction

  function automatic int chan_lsb(input int c, input int w);
    return c * w;
  endfunction

endpackage

// File: rtl/multichannel_decimator_lane.sv
// One channel of the decimator datapath.
// Build option: MULTICHANNEL_DECIMATOR_DUMP_EN selects integrate-and-dump
// (frame sum); without it the lane forwards the closing sample.
// Ports:
//   i_clk, i_reset_n : clock, async active-low reset
//   i_ce             : sample strobe
//   i_restart        : ratio load, discards any partial frame
//   i_close          : this i_ce sample closes the frame
//   i_sample [W]     : signed input sample
//   o_result [OW]    : signed result to capture when the frame closes
module decimator_lane #(
  parameter int W  = 10,
  parameter int OW = 16
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_ce,
  input  logic          i_restart,
  input  logic          i_close,
  input  logic [W-1:0]  i_sample,
  output logic [OW-1:0] o_result
);

  logic [OW-1:0] sample_x;
  assign sample_x = {{(OW-W){i_sample[W-1]}}, i_sample};

`ifdef MULTICHANNEL_DECIMATOR_DUMP_EN
  logic [OW-1:0] acc_q;
  logic [OW-1:0] base;
  logic [OW-1:0] sum;

  // A restart in the same cycle as a sample makes that sample the first
  // of the new frame, so the stale accumulator is bypassed.
  always_comb begin
    base = i_restart ? '0 : acc_q;
    sum  = base + sample_x;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      acc_q <= '0;
    else if (i_ce)
      acc_q <= i_close ? '0 : sum;
    else if (i_restart)
      acc_q <= '0;
  end

  assign o_result = sum;
`else
  logic unused_ports;
  assign unused_ports = ^{i_clk, i_reset_n, i_ce, i_restart, i_close};
  assign o_result     = sample_x;
`endif

endmodule

// File: rtl/multichannel_decimator.sv
// Programmable-ratio multi-channel decimator with a single-entry
// valid/ready output register and sticky overrun flag.
// Build option: MULTICHANNEL_DECIMATOR_DUMP_EN enables integrate-and-dump.
// Ports:
//   i_clk, i_reset_n        : clock, async active-low reset
//   i_ce                    : input sample strobe
//   i_data [CH*W]           : channel c at [c*W +: W], signed
//   i_ratio, i_ratio_load   : ratio request and its load strobe
//   o_data [CH*OW]          : channel c at [c*OW +: OW], signed
//   o_valid, i_ready        : output handshake
//   o_overrun, i_overrun_clr: sticky overrun flag and its clear
//   o_ratio                 : ratio in effect
module multichannel_decimator
  import multichannel_decimator_pkg::*;
#(
  parameter  int W    = 10,
  parameter  int CH   = 2,
  parameter  int RMAX = 32,
  parameter  int RW   = $clog2(RMAX + 1),
  localparam int OW   = out_width(W, RW)
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_ce,
  input  logic [CH*W-1:0] i_data,
  input  logic [RW-1:0]   i_ratio,
  input  logic            i_ratio_load,
  output logic [CH*OW-1:0] o_data,
  output logic            o_valid,
  input  logic            i_ready,
  output logic            o_overrun,
  input  logic            i_overrun_clr,
  output logic [RW-1:0]   o_ratio
);

  logic [RW-1:0]    cnt_q;
  logic [RW-1:0]    ratio_new;
  logic [RW-1:0]    ratio_eff;
  logic [RW-1:0]    cnt_eff;
  logic             close;
  logic             accept;
  logic             overrun_set;
  logic [CH*OW-1:0] lane_result;

  assign ratio_new = RW'(clamp_ratio(32'(i_ratio), RMAX));

  // A load in the same cycle as i_ce restarts the frame at count 0 under
  // the new ratio, so the close decision uses the post-load view.
  always_comb begin
    ratio_eff   = i_ratio_load ? ratio_new : o_ratio;
    cnt_eff     = i_ratio_load ? '0 : cnt_q;
    close       = i_ce && (cnt_eff == ratio_eff - RW'(1));
    accept      = o_valid && i_ready;
    overrun_set = close && o_valid && !i_ready;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_ratio <= RW'(1);
      cnt_q   <= '0;
    end else begin
      if (i_ratio_load)
        o_ratio <= ratio_new;
      if (close)
        cnt_q <= '0;
      else if (i_ce)
        cnt_q <= cnt_eff + RW'(1);
      else if (i_ratio_load)
        cnt_q <= '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      if (close) begin
        o_data  <= lane_result;
        o_valid <= 1'b1;
      end else if (accept) begin
        o_valid <= 1'b0;
      end
      if (overrun_set)
        o_overrun <= 1'b1;
      else if (i_overrun_clr)
        o_overrun <= 1'b0;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_lane
    localparam int ILSB = chan_lsb(c, W);
    localparam int OLSB = chan_lsb(c, OW);
    decimator_lane #(
      .W  (W),
      .OW (OW)
    ) u_lane (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_ce      (i_ce),
      .i_restart (i_ratio_load),
      .i_close   (close),
      .i_sample  (i_data[ILSB +: W]),
      .o_result  (lane_result[OLSB +: OW])
    );
  end

endmodule

// File: tb/tb_multichannel_decimator.sv
module tb_multichannel_decimator;
  import multichannel_decimator_pkg::*;

  localparam int W    = 10;
  localparam int CH   = 2;
  localparam int RMAX = 32;
  localparam int RW   = $clog2(RMAX + 1);
  localparam int OW   = W + RW;

  logic            i_clk = 1'b0;
  logic            i_reset_n;
  logic            i_ce;
  logic [CH*W-1:0] i_data;
  logic [RW-1:0]   i_ratio;
  logic            i_ratio_load;
  logic [CH*OW-1:0] o_data;
  logic            o_valid;
  logic            i_ready;
  logic            o_overrun;
  logic            i_overrun_clr;
  logic [RW-1:0]   o_ratio;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [OW-1:0] ch0;
  logic signed [OW-1:0] ch1;
  ratio_t               ratio_seen;
  assign ch0        = o_data[0 +: OW];
  assign ch1        = o_data[OW +: OW];
  assign ratio_seen = o_ratio;

  always #5 i_clk = ~i_clk;

  multichannel_decimator #(
    .W    (W),
    .CH   (CH),
    .RMAX (RMAX)
  ) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_ce          (i_ce),
    .i_data        (i_data),
    .i_ratio       (i_ratio),
    .i_ratio_load  (i_ratio_load),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_overrun     (o_overrun),
    .i_overrun_clr (i_overrun_clr),
    .o_ratio       (o_ratio)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs set before this are sampled at the edge,
  // outputs are read 1ns after it.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_in(input int d0, input int d1);
    i_data = {W'(d1), W'(d0)};
  endtask

  task automatic load(input int r);
    i_ratio      = RW'(r);
    i_ratio_load = 1'b1;
    i_ce         = 1'b0;
    tick();
    i_ratio_load = 1'b0;
  endtask

  task automatic sample(input int d0, input int d1);
    set_in(d0, d1);
    i_ce = 1'b1;
    tick();
    i_ce = 1'b0;
  endtask

  initial begin
    i_reset_n     = 1'b0;
    i_ce          = 1'b0;
    i_data        = '0;
    i_ratio       = '0;
    i_ratio_load  = 1'b0;
    i_ready       = 1'b0;
    i_overrun_clr = 1'b0;
    tick();
    tick();
    check("rst_data",    $signed({1'b0, o_data}), 0);
    check("rst_valid",   {31'd0, o_valid}, 0);
    check("rst_overrun", {31'd0, o_overrun}, 0);
    check("rst_ratio",   {26'd0, ratio_seen}, 1);
    i_reset_n = 1'b1;
    tick();

`ifdef MULTICHANNEL_DECIMATOR_DUMP_EN
    // Integrate-and-dump: frame sums, including the negative full-scale case.
    i_ready = 1'b1;
    load(4);
    for (int k = 1; k <= 4; k++) begin
      sample(100, -512);
      check("dump_valid", {31'd0, o_valid}, (k == 4) ? 1 : 0);
    end
    check("dump_ch0", ch0, 400);
    check("dump_ch1", ch1, -2048);
    tick();
    check("dump_drop", {31'd0, o_valid}, 0);

    // Asynchronous reset mid-frame, then a clean frame.
    sample(50, 50);
    sample(50, 50);
    #2;
    i_reset_n = 1'b0;
    #1;
    check("mrst_data",  $signed({1'b0, o_data}), 0);
    check("mrst_valid", {31'd0, o_valid}, 0);
    check("mrst_ratio", {26'd0, ratio_seen}, 1);
    tick();
    i_reset_n = 1'b1;
    tick();
    load(4);
    for (int k = 1; k <= 4; k++) begin
      sample(k, -k);
      check("clean_valid", {31'd0, o_valid}, (k == 4) ? 1 : 0);
    end
    check("clean_ch0", ch0, 10);
    check("clean_ch1", ch1, -10);
`else
    // Default ratio 1: continuous pass-through with i_ce held high.
    i_ready = 1'b1;
    set_in(5, -3);
    i_ce = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("r1_valid",   {31'd0, o_valid}, 1);
      check("r1_ch0",     ch0, 5);
      check("r1_ch1",     ch1, -3);
      check("r1_overrun", {31'd0, o_overrun}, 0);
    end
    i_ce = 1'b0;
    tick();
    check("r1_drop", {31'd0, o_valid}, 0);

    // Ratio 4, sample mode.
    load(4);
    check("r4_ratio", {26'd0, ratio_seen}, 4);
    for (int k = 1; k <= 8; k++) begin
      sample(k, -k);
      check("r4_valid", {31'd0, o_valid}, (k % 4 == 0) ? 1 : 0);
      if (k == 4) begin
        check("r4_ch0_a", ch0, 4);
        check("r4_ch1_a", ch1, -4);
      end
      if (k == 8) begin
        check("r4_ch0_b", ch0, 8);
        check("r4_ch1_b", ch1, -8);
      end
    end
    tick();
    check("r4_drop", {31'd0, o_valid}, 0);

    // Clamping.
    load(0);
    check("clamp_zero", {26'd0, ratio_seen}, 1);
    load(RMAX + 1);
    check("clamp_over", {26'd0, ratio_seen}, RMAX);
    load(63);
    check("clamp_max", {26'd0, ratio_seen}, RMAX);
    load(RMAX);
    check("clamp_edge", {26'd0, ratio_seen}, RMAX);

    // Mid-frame reload coinciding with a sample.
    load(4);
    sample(1, -1);
    sample(2, -2);
    check("reload_pre", {31'd0, o_valid}, 0);
    i_ratio      = RW'(3);
    i_ratio_load = 1'b1;
    sample(9, -9);
    i_ratio_load = 1'b0;
    check("reload_ratio", {26'd0, ratio_seen}, 3);
    check("reload_abort", {31'd0, o_valid}, 0);
    sample(10, -10);
    check("reload_mid", {31'd0, o_valid}, 0);
    sample(11, -11);
    check("reload_valid", {31'd0, o_valid}, 1);
    check("reload_ch0", ch0, 11);
    check("reload_ch1", ch1, -11);
    tick();

    // Counter stalls across i_ce gaps.
    load(3);
    sample(7, -7);
    tick();
    tick();
    check("gap_a", {31'd0, o_valid}, 0);
    sample(8, -8);
    tick();
    check("gap_b", {31'd0, o_valid}, 0);
    sample(9, -9);
    check("gap_valid", {31'd0, o_valid}, 1);
    check("gap_ch0", ch0, 9);

    // Load to ratio 1 with a sample in the same cycle.
    i_ratio      = RW'(1);
    i_ratio_load = 1'b1;
    sample(12, -12);
    i_ratio_load = 1'b0;
    check("ldce_valid", {31'd0, o_valid}, 1);
    check("ldce_ch0",   ch0, 12);
    check("ldce_ch1",   ch1, -12);
    tick();

    // Overrun with downstream stalled.
    i_ready = 1'b0;
    load(2);
    sample(1, -1);
    check("ov_pre", {31'd0, o_valid}, 0);
    sample(2, -2);
    check("ov_valid1", {31'd0, o_valid}, 1);
    check("ov_flag1",  {31'd0, o_overrun}, 0);
    check("ov_ch0_1",  ch0, 2);
    sample(3, -3);
    check("ov_hold",   ch0, 2);
    check("ov_flag_h", {31'd0, o_overrun}, 0);
    sample(4, -4);
    check("ov_flag2",  {31'd0, o_overrun}, 1);
    check("ov_ch0_2",  ch0, 4);
    check("ov_ch1_2",  ch1, -4);
    i_overrun_clr = 1'b1;
    tick();
    check("ov_clr",       {31'd0, o_overrun}, 0);
    check("ov_clr_valid", {31'd0, o_valid}, 1);
    sample(5, -5);
    check("ov_clr_keep", {31'd0, o_overrun}, 0);
    sample(6, -6);
    check("ov_set_wins", {31'd0, o_overrun}, 1);
    check("ov_ch0_3",    ch0, 6);
    tick();
    check("ov_clr2", {31'd0, o_overrun}, 0);
    i_overrun_clr = 1'b0;
    i_ready       = 1'b1;
    tick();
    check("ov_accept", {31'd0, o_valid}, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multichannel_decimator.md
# multichannel_decimator

Programmable-ratio, multi-channel decimator for the post-CIC sample path. It takes CH parallel signed channels on a shared input strobe. It emits one result per channel for every R accepted samples, with R set at run time. Results leave through a single-entry valid/ready output register with overrun detection. It succeeds the fixed-ratio decimator; the decimation ratio is now exact (R inputs per output, not R+1).

## Interface
- W, 10: input sample width per channel (signed)
- CH, 2: number of parallel channels
- RMAX, 32: largest supported ratio
- RW, $clog2(RMAX+1): ratio/counter width
- OW, W+RW: output width per channel (derived; do not override)
- i_clk  in  1  single clock; all logic on rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_ce  in  1  input sample strobe; one sample per channel accepted per high cycle
- i_data  in  CH*W  channel c at bits [c*W +: W], signed
- i_ratio  in  RW  requested decimation ratio
- i_ratio_load  in  1  strobe: latch i_ratio and restart frame
- o_data  out  CH*OW  channel c at bits [c*OW +: OW], signed
- o_valid  out  1  result held in output register
- i_ready  in  1  downstream accepts result when o_valid && i_ready
- o_overrun  out  1  sticky: an unaccepted result was overwritten
- i_overrun_clr  in  1  clears o_overrun
- o_ratio  out  RW  ratio currently in effect

## Operation
- Reset values: o_data 0, o_valid 0, o_overrun 0, o_ratio 1, internal counter 0, accumulators 0.
- Ratio latch: on i_ratio_load, o_ratio is set as follows. If i_ratio is 0, it becomes 1. If i_ratio > RMAX, it becomes RMAX. Otherwise it becomes i_ratio.
- A ratio load also aborts the current frame. The counter and accumulators clear, and no partial result is emitted.
- Ratio load and i_ce in the same cycle: the load is applied, and that sample is the first sample of the new frame under the new ratio.
- Frame counter runs 0..o_ratio-1. It advances only on i_ce. The sample taken at count o_ratio-1 closes the frame, and the counter wraps to 0.
- Sample mode (macro absent): the result is the closing sample of the frame, sign-extended to OW.
- Ratio 1 is pass-through: every i_ce produces a result.
- Output register behaviour on frame close:
  - Load o_data and set o_valid.
  - If o_valid && !i_ready in that cycle, the old result is lost and o_overrun is set.
  - If o_valid && i_ready in that cycle, there is no overrun and o_valid stays 1.
- Without a frame close, o_valid drops when o_valid && i_ready.
- i_overrun_clr clears o_overrun. If a clear and a new overrun occur in the same cycle, the set wins.
- i_ready is ignored while o_valid is 0.

## Timing
- Latency: o_valid rises on the clock edge after the i_ce cycle that closes the frame. o_data is valid from that same edge.
- Throughput: one result per o_ratio accepted samples. At ratio 1 with i_ce held high, o_valid can stay high continuously.
- i_ce gaps stall the counter without losing state.
- Reset may be asserted mid-frame at any time. It takes effect immediately (asynchronous). Deassertion must be synchronised to i_clk by the system reset logic.

## Configuration
- MULTICHANNEL_DECIMATOR_DUMP_EN defined: integrate-and-dump mode.
  - Each channel accumulates its o_ratio samples in OW bits; no overflow is possible since RMAX < 2^RW.
  - The result is the signed frame sum; there is no division.
  - The accumulator restarts on the sample after frame close. The closing sample is included in the emitted sum.
- Macro undefined: sample mode as described in Operation. The accumulator logic is not built.

## Structure
- Package multichannel_decimator_pkg holds the following:
  - ratio_t (logic [RW-1:0]) and the ratio clamp function.
  - The output-width derivation constant.
  - The channel slice helper function.
- Sub-module decimator_lane holds one channel's select/accumulate datapath. It is generated CH times.
- The counter, ratio register, output handshake and overrun logic stay in the top module.

## Test plan
- Default ratio: after reset, drive i_ce high continuously with i_ready=1 and channel 0 = 5. Expect o_valid high every cycle with o_data ch0 = 5 (ratio 1).
- Ratio 4, sample mode: load 4, then feed ch0 = 1,2,3,…,8 and ch1 = -1,…,-8. Expect two results: (4,-4) then (8,-8), each one cycle after the 4th and 8th i_ce.
- Clamp: load i_ratio=0 and expect o_ratio=1. Load i_ratio=RMAX+1 and expect o_ratio=RMAX.
- Mid-frame reload: with ratio 4, after 2 samples load 3 in the same cycle as a sample valued 9. Expect no result from the aborted frame, and the next result after 2 more samples.
- Overrun: ratio 2 with i_ready=0. The first result gives o_overrun=0; the second gives o_overrun=1 with the newer data. Pulse i_overrun_clr and expect o_overrun=0.
- Dump mode (macro defined): ratio 4 with ch0 = 100,100,100,100 gives o_data 400. With ch1 = -(2^(W-1)) on all samples, expect -4·2^(W-1) exactly. Assert reset mid-frame and expect all outputs 0 and the next frame to start clean.
